fetch_buffer: RTL

// - Instruction prefetch queue between instruction-memory fetch and the decode stage.
// - Decouples fetch from decode stalls; absorbs up to DEPTH fetched words.
// - Presents one {instr, pc} per cycle to decode.
// - Decode slices dec_instr[31:7] into the immediate generator and control decoder.

---
 rtl/decode_pkg.sv | 13 +
 rtl/fetch_buffer.sv | 103 ++++++++++
 2 files changed

// File: rtl/decode_pkg.sv
// Shared decode-side types: queued fetch entry layout and the canonical RV32I NOP.
package decode_pkg;

  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  localparam logic [XLEN-1:0] RV_NOP = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction prefetch queue between I-mem fetch and decode; circular DEPTH-entry FIFO.
// Optional zero-latency empty-queue bypass enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_buffer
  import decode_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XLEN,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fetch_valid,
  input  logic [DATA_WIDTH-1:0]  fetch_instr,
  input  logic [DATA_WIDTH-1:0]  fetch_pc,
  output logic                   fetch_ready,
  input  logic                   flush,
  output logic                   dec_valid,
  output logic [DATA_WIDTH-1:0]  dec_instr,
  output logic [DATA_WIDTH-1:0]  dec_pc,
  output logic [DATA_WIDTH-1:0]  dec_pc_plus4,
  input  logic                   dec_ready,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  r_wr_ptr;
  logic [CW-1:0]  r_count;

  logic           w_empty;
  logic           w_full;
  logic           w_byp;
  logic           w_push;
  logic           w_pop;
  fetch_entry_t   w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  assign fetch_ready = rst_n & ~w_full;

`ifdef FETCH_BUF_BYPASS_EN
  assign w_byp = w_empty & fetch_valid & ~flush;
`else
  assign w_byp = 1'b0;
`endif

  // A bypassed word consumed by decode in the same cycle is never written.
  assign w_push = fetch_valid & fetch_ready & ~flush & ~(w_byp & dec_ready);
  assign w_pop  = dec_valid & dec_ready & ~w_byp;

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    dec_valid = 1'b0;
    dec_instr = DATA_WIDTH'(RV_NOP);
    dec_pc    = '0;
    if (!flush) begin
      if (w_byp) begin
        dec_valid = 1'b1;
        dec_instr = fetch_instr;
        dec_pc    = fetch_pc;
      end else if (!w_empty) begin
        dec_valid = 1'b1;
        dec_instr = w_head.instr;
        dec_pc    = w_head.pc;
      end
    end
  end

  assign dec_pc_plus4 = dec_pc + DATA_WIDTH'(4);
  assign count        = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: entries are only observable through count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= '{instr: fetch_instr, pc: fetch_pc};
    end
  end

endmodule
